// File: rtl/instr_encoder.sv
// MIPS instruction encoder/loader: packs symbolic instruction requests into
// 32-bit MIPS words and writes them to consecutive instruction-memory addresses.
module instr_encoder #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_kind,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [15:0]       req_imm,
    input  logic [ADDR_W-1:0] req_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic              state_dbg
);

    localparam logic [2:0] KIND_ADD  = 3'd0;
    localparam logic [2:0] KIND_SUB  = 3'd1;
    localparam logic [2:0] KIND_ADDI = 3'd2;
    localparam logic [2:0] KIND_LW   = 3'd3;
    localparam logic [2:0] KIND_SW   = 3'd4;
    localparam logic [2:0] KIND_BEQ  = 3'd5;
    localparam logic [2:0] KIND_J    = 3'd6;
    localparam logic [2:0] KIND_ILL  = 3'd7;

    localparam logic [ADDR_W:0]   DEPTH_C = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W-1:0] BASE_A  = BASE[ADDR_W-1:0];

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               legal;
    logic [ADDR_W-1:0]  pc_addr;
    logic [15:0]        beq_off;
    logic [31:0]        enc_word;

    // Handshake: a request transfers on a posedge where req_valid && req_ready;
    // all req_* fields are sampled on that edge. There is no buffering, so
    // req_valid may drop at any time while req_ready is low.

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: an illegal kind is consumed without leaving IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && legal) state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / handshake logic
    always_comb begin
        full      = (count == DEPTH_C);
        req_ready = (state == IDLE) && !full && !rst;
        accept    = req_valid && req_ready;
        legal     = (req_kind != KIND_ILL);
        state_dbg = state;
    end

    // Branch offset is relative to the instruction after the BEQ itself
    always_comb begin
        pc_addr  = BASE_A + count[ADDR_W-1:0];
        beq_off  = 16'(req_target) - 16'(pc_addr) - 16'd1;
        enc_word = 32'h0;
        case (req_kind)
            KIND_ADD:  enc_word = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h20};
            KIND_SUB:  enc_word = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h22};
            KIND_ADDI: enc_word = {6'h08, req_rs, req_rt, req_imm};
            KIND_LW:   enc_word = {6'h23, req_rs, req_rt, req_imm};
            KIND_SW:   enc_word = {6'h2B, req_rs, req_rt, req_imm};
            KIND_BEQ:  enc_word = {6'h04, req_rs, req_rt, beq_off};
            KIND_J:    enc_word = {6'h02, 26'(req_target)};
            default:   enc_word = 32'h0;
        endcase
    end

    // Write port and bookkeeping; address/data hold between writes
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= BASE_A;
            imem_wdata <= 32'h0;
            count      <= '0;
            err        <= 1'b0;
        end else begin
            imem_we <= accept && legal;
            if (accept && legal) begin
                imem_addr  <= pc_addr;
                imem_wdata <= enc_word;
            end
            if (accept && !legal) begin
                err <= 1'b1;
            end
            if (state == WRITE) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder (DEPTH=4 so the full condition is reachable).
module tb_instr_encoder;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;
  localparam int BASE   = 0;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_kind;
  logic [4:0]        req_rs;
  logic [4:0]        req_rt;
  logic [4:0]        req_rd;
  logic [15:0]       req_imm;
  logic [ADDR_W-1:0] req_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;
  logic              state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_kind   (req_kind),
    .req_rs     (req_rs),
    .req_rt     (req_rt),
    .req_rd     (req_rd),
    .req_imm    (req_imm),
    .req_target (req_target),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .full       (full),
    .err        (err),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // driver: waits (bounded) for ready, issues one request, returns the
  // observations from the cycle right after the accept edge
  task automatic drive_req(input logic [2:0] kind, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd,
                           input logic [15:0] imm, input logic [ADDR_W-1:0] tgt,
                           output logic obs_we, output logic [ADDR_W-1:0] obs_addr,
                           output logic [31:0] obs_wdata, output logic obs_ready);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_timeout: req_ready=%b required 1", req_ready);
    end
    req_kind   = kind;
    req_rs     = rs;
    req_rt     = rt;
    req_rd     = rd;
    req_imm    = imm;
    req_target = tgt;
    req_valid  = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    obs_we    = imem_we;
    obs_addr  = imem_addr;
    obs_wdata = imem_wdata;
    obs_ready = req_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({imem_we, imem_addr, imem_wdata, count, full, err, req_ready, state_dbg} !==
        {1'b0, 10'd0, 32'h0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: we=%b addr=%0d wdata=%h count=%0d full=%b err=%b ready=%b st=%b required all zero",
               imem_we, imem_addr, imem_wdata, count, full, err, req_ready, state_dbg);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b required 1", req_ready);
    end
  endtask

  task automatic test_add();
    logic we, rdy;
    logic [ADDR_W-1:0] a;
    logic [31:0] w;
    do_reset();
    drive_req(3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 10'd0, we, a, w, rdy);
    n_checks++;
    if ({we, a, w, rdy, state_dbg} !== {1'b1, 10'd0, 32'h00221820, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL add_write: we=%b addr=%0d wdata=%h ready=%b st=%b required 1 0 00221820 0 1",
               we, a, w, rdy, state_dbg);
    end
    @(negedge clk);
    n_checks++;
    if ({imem_we, count, imem_addr, imem_wdata} !== {1'b0, 11'd1, 10'd0, 32'h00221820}) begin
      n_fail++;
      $display("FAIL add_after: we=%b count=%0d addr=%0d wdata=%h required 0 1 0 00221820",
               imem_we, count, imem_addr, imem_wdata);
    end
  endtask

  task automatic test_sub_addi();
    logic we, rdy;
    logic [ADDR_W-1:0] a;
    logic [31:0] w;
    do_reset();
    drive_req(3'd1, 5'd4, 5'd5, 5'd6, 16'h0, 10'd0, we, a, w, rdy);
    n_checks++;
    if ({we, a, w, rdy} !== {1'b1, 10'd0, 32'h00853022, 1'b0}) begin
      n_fail++;
      $display("FAIL sub_write: we=%b addr=%0d wdata=%h ready=%b required 1 0 00853022 0", we, a, w, rdy);
    end
    drive_req(3'd2, 5'd0, 5'd8, 5'd0, 16'hFFFF, 10'd0, we, a, w, rdy);
    n_checks++;
    if ({we, a, w, rdy} !== {1'b1, 10'd1, 32'h2008FFFF, 1'b0}) begin
      n_fail++;
      $display("FAIL addi_write: we=%b addr=%0d wdata=%h ready=%b required 1 1 2008ffff 0", we, a, w, rdy);
    end
    @(negedge clk);
    n_checks++;
    if (count !== 11'd2) begin
      n_fail++;
      $display("FAIL sub_addi_count: got %0d required 2", count);
    end
  endtask

  // continues from count=2 left by test_sub_addi
  task automatic test_beq_j();
    logic we, rdy;
    logic [ADDR_W-1:0] a;
    logic [31:0] w;
    drive_req(3'd5, 5'd1, 5'd2, 5'd0, 16'h0, 10'd0, we, a, w, rdy);
    n_checks++;
    if ({we, a, w} !== {1'b1, 10'd2, 32'h1022FFFD}) begin
      n_fail++;
      $display("FAIL beq_write: we=%b addr=%0d wdata=%h required 1 2 1022fffd", we, a, w);
    end
    drive_req(3'd6, 5'd0, 5'd0, 5'd0, 16'h0, 10'h010, we, a, w, rdy);
    n_checks++;
    if ({we, a, w} !== {1'b1, 10'd3, 32'h08000010}) begin
      n_fail++;
      $display("FAIL j_write: we=%b addr=%0d wdata=%h required 1 3 08000010", we, a, w);
    end
    @(negedge clk);
    n_checks++;
    if ({count, full, req_ready} !== {11'd4, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL full_flag: count=%0d full=%b ready=%b required 4 1 0", count, full, req_ready);
    end
  endtask

  // held request while full must never write
  task automatic test_full_hold();
    int we_seen;
    we_seen = 0;
    req_kind  = 3'd0;
    req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (imem_we !== 1'b0 || req_ready !== 1'b0) we_seen++;
    end
    req_valid = 1'b0;
    n_checks++;
    if (we_seen != 0 || count !== 11'd4) begin
      n_fail++;
      $display("FAIL full_hold: bad_cycles=%0d count=%0d required 0 4", we_seen, count);
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    @(negedge clk);
    req_kind  = 3'd0;
    req_rs    = 5'd1;
    req_rt    = 5'd2;
    req_rd    = 5'd3;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    n_checks++;
    if (imem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL midwrite_we_before: got %b required 1", imem_we);
    end
    @(negedge clk);
    n_checks++;
    if ({imem_we, count, req_ready, state_dbg} !== {1'b0, 11'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midwrite_abort: we=%b count=%0d ready=%b st=%b required 0 0 0 0",
               imem_we, count, req_ready, state_dbg);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (count !== 11'd0) begin
      n_fail++;
      $display("FAIL midwrite_count: got %0d required 0", count);
    end
  endtask

  task automatic test_lw_sw();
    logic we, rdy;
    logic [ADDR_W-1:0] a;
    logic [31:0] w;
    do_reset();
    drive_req(3'd3, 5'd29, 5'd8, 5'd0, 16'h0004, 10'd0, we, a, w, rdy);
    n_checks++;
    if ({we, a, w} !== {1'b1, 10'd0, 32'h8FA80004}) begin
      n_fail++;
      $display("FAIL lw_write: we=%b addr=%0d wdata=%h required 1 0 8fa80004", we, a, w);
    end
    drive_req(3'd4, 5'd29, 5'd8, 5'd0, 16'h0004, 10'd0, we, a, w, rdy);
    n_checks++;
    if ({we, a, w} !== {1'b1, 10'd1, 32'hAFA80004}) begin
      n_fail++;
      $display("FAIL sw_write: we=%b addr=%0d wdata=%h required 1 1 afa80004", we, a, w);
    end
  endtask

  task automatic test_illegal();
    logic we, rdy;
    logic [ADDR_W-1:0] a;
    logic [31:0] w;
    do_reset();
    drive_req(3'd7, 5'd1, 5'd1, 5'd1, 16'h1234, 10'd5, we, a, w, rdy);
    n_checks++;
    if ({we, err, count, rdy} !== {1'b0, 1'b1, 11'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL illegal: we=%b err=%b count=%0d ready=%b required 0 1 0 1", we, err, count, rdy);
    end
    drive_req(3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 10'd0, we, a, w, rdy);
    @(negedge clk);
    n_checks++;
    if ({we, a, w, err, count} !== {1'b1, 10'd0, 32'h00221820, 1'b1, 11'd1}) begin
      n_fail++;
      $display("FAIL illegal_sticky: we=%b addr=%0d wdata=%h err=%b count=%0d required 1 0 00221820 1 1",
               we, a, w, err, count);
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_kind   = 3'd0;
    req_rs     = 5'd0;
    req_rt     = 5'd0;
    req_rd     = 5'd0;
    req_imm    = 16'h0;
    req_target = '0;
    test_reset();
    test_add();
    test_sub_addi();
    test_beq_j();
    test_full_hold();
    test_reset_mid_write();
    test_lw_sw();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
